// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline latch: aligns load data, gates writeback controls,
// counts retired instructions and freezes the pipe after HALT.
module mem_wb_latch #(
    parameter int NB_REG  = 32,
    parameter int NB_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic               i_halt_instr,
    input  logic [NB_REG-1:0]  i_alu_result,
    input  logic [NB_REG-1:0]  i_mem_rdata,
    input  logic [NB_REG-1:0]  i_pcplus8,
    input  logic [1:0]         i_byte_off,
    input  logic [1:0]         i_load_size,
    input  logic               i_load_unsigned,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    input  logic               i_RegWrite,
    input  logic               i_MemToReg,
    input  logic               i_isJal,
    output logic [NB_REG-1:0]  o_alu_result,
    output logic [NB_REG-1:0]  o_data_from_mem,
    output logic [NB_REG-1:0]  o_pcplus8,
    output logic [NB_ADDR-1:0] o_rd_addr,
    output logic               o_RegWrite,
    output logic               o_MemToReg,
    output logic               o_isJal,
    output logic               o_valid,
    output logic               o_halt,
    output logic [31:0]        o_retired_count
);

    logic              is_byte;
    logic              is_half;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic              ext_bit;
    logic [NB_REG-1:0] aligned;
    logic              load_en;
    logic [31:0]       cnt_q;

    assign is_byte = (i_load_size == 2'b00);
    assign is_half = (i_load_size == 2'b01);

    // Little-endian lane select; half loads ignore the low offset bit.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        ext_bit  = 1'b0;
        aligned  = i_mem_rdata;
        unique case (i_byte_off)
            2'd0: byte_sel = i_mem_rdata[7:0];
            2'd1: byte_sel = i_mem_rdata[15:8];
            2'd2: byte_sel = i_mem_rdata[23:16];
            2'd3: byte_sel = i_mem_rdata[31:24];
        endcase
        if (i_byte_off[1]) begin
            half_sel = i_mem_rdata[31:16];
        end else begin
            half_sel = i_mem_rdata[15:0];
        end
        unique case (1'b1)
            is_byte: begin
                ext_bit = ~i_load_unsigned & byte_sel[7];
                aligned = {{(NB_REG-8){ext_bit}}, byte_sel};
            end
            is_half: begin
                ext_bit = ~i_load_unsigned & half_sel[15];
                aligned = {{(NB_REG-16){ext_bit}}, half_sel};
            end
            default: aligned = i_mem_rdata;
        endcase
    end

    assign load_en = ~o_halt & ~i_flush & ~i_stall;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_alu_result    <= '0;
            o_data_from_mem <= '0;
            o_pcplus8       <= '0;
            o_rd_addr       <= '0;
            o_RegWrite      <= 1'b0;
            o_MemToReg      <= 1'b0;
            o_isJal         <= 1'b0;
            o_valid         <= 1'b0;
            o_halt          <= 1'b0;
            cnt_q           <= '0;
        end else if (o_halt || i_flush) begin
            // Bubble: only the control bits matter, data is left as is.
            o_RegWrite <= 1'b0;
            o_MemToReg <= 1'b0;
            o_isJal    <= 1'b0;
            o_valid    <= 1'b0;
        end else if (load_en) begin
            o_alu_result    <= i_alu_result;
            o_data_from_mem <= aligned;
            o_pcplus8       <= i_pcplus8;
            o_rd_addr       <= i_rd_addr;
            o_RegWrite      <= i_RegWrite & i_valid & (i_rd_addr != '0);
            o_MemToReg      <= i_MemToReg & i_valid;
            o_isJal         <= i_isJal & i_valid;
            o_valid         <= i_valid;
            o_halt          <= i_valid & i_halt_instr;
            cnt_q           <= cnt_q + {31'd0, i_valid};
        end
    end

    assign o_retired_count = cnt_q;

endmodule
